dbus_mem_responder: RTL

- Memory-side responder for the core's data bus: it answers the `dbus_req_t` / `dbus_resp_t` handshake issued by the memory stage and by the MMU page-table walker.
- It holds a word-addressed backing RAM, applies a fixed programmable response latency, and performs byte-strobed writes.
- It reports out-of-range accesses.
- It sits at the far end of the data bus in simulation and FPGA bring-up builds, in place of the external memory system.

---
 rtl/dbus_mem_responder_pkg.sv | 38 +++
 rtl/dbus_mem_responder_dmem_ram.sv | 32 +++
 rtl/dbus_mem_responder.sv | 117 +++++++++++
 3 files changed

// File: rtl/dbus_mem_responder_pkg.sv
// Shared types for the data-bus memory responder.
//   msize_t      : access size tag carried on the request (informational)
//   strobe_t     : 8-lane byte write strobe, all-zero marks a read
//   dbus_req_t   : valid / addr / size / strobe / data
//   dbus_resp_t  : addr_ok / data_ok / data
//   dmem_state_t : responder FSM states
package dbus_mem_responder_pkg;

  typedef enum logic [1:0] {
    MSIZE1,
    MSIZE2,
    MSIZE4,
    MSIZE8
  } msize_t;

  typedef logic [7:0] strobe_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    strobe_t     strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

endpackage

// File: rtl/dbus_mem_responder_dmem_ram.sv
// Backing store for the responder: single-port DEPTH_WORDS x 64 array.
//   clk   : write clock
//   we    : per-byte write enable (lane i covers bits 8i+7:8i)
//   addr  : word index
//   wdata : write data
//   rdata : asynchronous read of the addressed word (pre-write value)
module dmem_ram
  import dbus_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned AW          = 12
) (
  input  logic          clk,
  input  strobe_t       we,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 8; i++) begin
      if (we[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dbus_mem_responder.sv
// Memory-side responder for the data bus: accepts one request at a time,
// waits LATENCY cycles, then returns a one-cycle addr_ok/data_ok response
// carrying the aligned 64-bit word and performs any strobed write.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset
//   dreq  : request (valid, addr, size, strobe, data)
//   dresp : response (addr_ok, data_ok, data); data is 0 unless data_ok
//   err   : pulses with data_ok when the access fell outside the RAM
module dbus_mem_responder
  import dbus_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       err
);

  localparam int unsigned AW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  LAT = 4'(LATENCY);

  dmem_state_t   state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic          accept;

  logic [AW-1:0] idx_q;
  logic          oor_q;
  strobe_t       strobe_q;
  logic [63:0]   data_q;

  logic [63:0]   word_off;
  logic          oor_in;
  logic [63:0]   rdata;
  strobe_t       we;

  // size does not affect the access; the strobe alone picks written bytes
  logic          unused_size;
  assign unused_size = ^dreq.size;

  // Range check on the full 64-bit offset; truncation to the RAM index
  // happens only when latching, so out-of-range never aliases into RAM.
  assign word_off = (dreq.addr - BASE_ADDR) >> 3;
  assign oor_in   = (dreq.addr < BASE_ADDR) || (word_off >= 64'(DEPTH_WORDS));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (dreq.valid) begin
          accept  = 1'b1;
          cnt_n   = LAT;
          state_n = (LAT == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_n = RESP;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      idx_q    <= '0;
      oor_q    <= 1'b0;
      strobe_q <= '0;
      data_q   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        idx_q    <= word_off[AW-1:0];
        oor_q    <= oor_in;
        strobe_q <= dreq.strobe;
        data_q   <= dreq.data;
      end
    end
  end

  // Write lands on the RESP edge; reset forces IDLE so a pending write is lost.
  assign we = ((state == RESP) && !oor_q) ? strobe_q : '0;

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .addr  (idx_q),
    .wdata (data_q),
    .rdata (rdata)
  );

  always_comb begin
    dresp = '0;
    err   = 1'b0;
    if (state == RESP) begin
      dresp.addr_ok = 1'b1;
      dresp.data_ok = 1'b1;
      dresp.data    = oor_q ? '0 : rdata;
      err           = oor_q;
    end
  end

endmodule
